// File: rtl/pe_inj_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_inj_arbiter
// Purpose  : Packet-atomic round-robin sharing of one router injection port
//            among NPE processing elements, with per-VC credit flow control.
// Revision : 1.0 - initial release
// ============================================================================
module pe_inj_arbiter #(
   parameter int NPE     = 4,
   parameter int DATAW   = 63,
   parameter int VCH     = 1,
   parameter int VCHW    = 0,
   parameter int CREDITS = 4
) (
   input  logic                        clk,
   input  logic                        rst_,
   input  logic [NPE-1:0]              pe_valid,
   input  logic [NPE*(DATAW+1)-1:0]    pe_data,
   input  logic [NPE*(VCHW+1)-1:0]     pe_vch,
   output logic [NPE-1:0]              pe_ack,
   input  logic [VCH:0]                credit_in,
   output logic [DATAW:0]              odata,
   output logic                        ovalid,
   output logic [VCHW:0]               ovch,
   output logic [2:0]                  grant_id,
   output logic                        busy,
   output logic                        err
);

   localparam int FW = DATAW + 1;
   localparam int VW = VCHW + 1;
   localparam int CW = $clog2(CREDITS + 1);
   localparam int PW = (NPE > 1) ? $clog2(NPE) : 1;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [PW-1:0]   grant_q, grant_d;
   logic [VW-1:0]   lock_vc_q, lock_vc_d;
   logic            err_q, err_d;
   logic [CW-1:0]   credit_q [VCH+1];
   logic [CW-1:0]   credit_d [VCH+1];
   logic [DATAW:0]  odata_q;
   logic            ovalid_q;
   logic [VW-1:0]   ovch_q;

   logic [DATAW:0]  flit_w [NPE];
   logic [VW-1:0]   vch_w  [NPE];
   logic [NPE-1:0]  head_w;
   logic [NPE-1:0]  tail_w;
   logic [NPE-1:0]  elig_w;
   logic [VCH:0]    cred_nz;
   logic            lock_ok;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   sel_idx;
   logic [NPE-1:0]  ack_w;
   logic            send_any;
   logic [DATAW:0]  out_flit;
   logic [VW-1:0]   out_vch;
   logic            proto_err;
   logic            ovf_err;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
      return (x == PW'(NPE - 1)) ? '0 : x + PW'(1);
   endfunction

   always_comb begin
      for (int v = 0; v <= VCH; v++) begin
         cred_nz[v] = (credit_q[v] != '0);
      end
   end

   // Flit type lives in the two MSBs: bit DATAW-1 marks a head, bit DATAW a tail.
   always_comb begin
      for (int i = 0; i < NPE; i++) begin
         flit_w[i] = pe_data[i*FW +: FW];
         vch_w[i]  = pe_vch[i*VW +: VW];
         head_w[i] = pe_data[i*FW + DATAW - 1];
         tail_w[i] = pe_data[i*FW + DATAW];
         elig_w[i] = 1'b0;
         for (int v = 0; v <= VCH; v++) begin
            if (pe_vch[i*VW +: VW] == VW'(v)) begin
               elig_w[i] = pe_valid[i] & cred_nz[v];
            end
         end
      end
   end

   always_comb begin
      lock_ok = 1'b0;
      for (int v = 0; v <= VCH; v++) begin
         if (lock_vc_q == VW'(v)) begin
            lock_ok = cred_nz[v];
         end
      end
   end

   always_comb begin
      int            cand;
      logic [PW-1:0] cidx;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cidx      = '0;
      for (int k = 0; k < NPE; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NPE) begin
            cand = cand - NPE;
         end
         cidx = PW'(cand);
         if (!win_found && elig_w[cidx] && head_w[cidx]) begin
            win_found = 1'b1;
            win_idx   = cidx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      grant_d   = grant_q;
      lock_vc_d = lock_vc_q;
      proto_err = 1'b0;
      ack_w     = '0;
      sel_idx   = grant_q;
      case (state_q)
         S_IDLE: begin
            sel_idx = win_idx;
            if (win_found) begin
               ack_w[win_idx] = 1'b1;
               if (tail_w[win_idx]) begin
                  rr_d = nxt(win_idx);
               end else begin
                  state_d   = S_LOCKED;
                  grant_d   = win_idx;
                  lock_vc_d = vch_w[win_idx];
               end
            end
            if (|(pe_valid & ~head_w)) begin
               proto_err = 1'b1;
            end
         end
         S_LOCKED: begin
            if (pe_valid[grant_q]) begin
               if (head_w[grant_q] || (vch_w[grant_q] != lock_vc_q)) begin
                  proto_err = 1'b1;
               end else if (lock_ok) begin
                  ack_w[grant_q] = 1'b1;
                  if (tail_w[grant_q]) begin
                     state_d = S_IDLE;
                     rr_d    = nxt(grant_q);
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign send_any = |ack_w;
   assign out_flit = flit_w[sel_idx];
   assign out_vch  = vch_w[sel_idx];

   // A simultaneous send and return on one VC cancel out; a return at full saturates.
   always_comb begin
      ovf_err = 1'b0;
      for (int v = 0; v <= VCH; v++) begin
         credit_d[v] = credit_q[v];
         if (send_any && (out_vch == VW'(v)) && !credit_in[v]) begin
            credit_d[v] = credit_q[v] - CW'(1);
         end else if (credit_in[v] && !(send_any && (out_vch == VW'(v)))) begin
            if (credit_q[v] == CW'(CREDITS)) begin
               ovf_err = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] + CW'(1);
            end
         end
      end
   end

   assign err_d = err_q | proto_err | ovf_err;

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         grant_q   <= '0;
         lock_vc_q <= '0;
         err_q     <= 1'b0;
         odata_q   <= '0;
         ovalid_q  <= 1'b0;
         ovch_q    <= '0;
         for (int v = 0; v <= VCH; v++) begin
            credit_q[v] <= CW'(CREDITS);
         end
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         lock_vc_q <= lock_vc_d;
         err_q     <= err_d;
         ovalid_q  <= send_any;
         if (send_any) begin
            odata_q <= out_flit;
            ovch_q  <= out_vch;
         end
         for (int v = 0; v <= VCH; v++) begin
            credit_q[v] <= credit_d[v];
         end
      end
   end

   assign pe_ack   = ack_w;
   assign odata    = odata_q;
   assign ovalid   = ovalid_q;
   assign ovch     = ovch_q;
   assign grant_id = 3'(grant_q);
   assign busy     = (state_q == S_LOCKED);
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_inj_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_inj_arbiter
// Purpose  : Scoreboard bench for pe_inj_arbiter with queue-driven PE models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_inj_arbiter;

   localparam int NPE     = 4;
   localparam int DATAW   = 63;
   localparam int VCH     = 1;
   localparam int VCHW    = 0;
   localparam int CREDITS = 4;
   localparam int FW      = DATAW + 1;
   localparam int VW      = VCHW + 1;

   logic                     clk = 1'b0;
   logic                     rst_;
   logic [NPE-1:0]           pe_valid;
   logic [NPE*FW-1:0]        pe_data;
   logic [NPE*VW-1:0]        pe_vch;
   logic [NPE-1:0]           pe_ack;
   logic [VCH:0]             credit_in;
   logic [DATAW:0]           odata;
   logic                     ovalid;
   logic [VCHW:0]            ovch;
   logic [2:0]               grant_id;
   logic                     busy;
   logic                     err;

   pe_inj_arbiter #(
      .NPE(NPE), .DATAW(DATAW), .VCH(VCH), .VCHW(VCHW), .CREDITS(CREDITS)
   ) dut (
      .clk(clk), .rst_(rst_),
      .pe_valid(pe_valid), .pe_data(pe_data), .pe_vch(pe_vch), .pe_ack(pe_ack),
      .credit_in(credit_in),
      .odata(odata), .ovalid(ovalid), .ovch(ovch),
      .grant_id(grant_id), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATAW:0] d;
      logic [VW-1:0]  v;
   } flit_t;

   flit_t          peq [NPE][$];
   flit_t          exp_q [$];
   flit_t          mon_e;
   int             checks = 0;
   int             errors = 0;
   int             ack_cnt [NPE];
   logic [NPE-1:0] last_ack;
   logic [VCH:0]   cred_pulse;
   bit             auto_ret;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, expv);
      end
   endtask

   function automatic flit_t mk(input int pe, input int seq, input logic [1:0] ty, input int vc);
      flit_t f;
      f.d          = '0;
      f.d[DATAW -: 2] = ty;
      f.d[15:8]    = 8'(pe);
      f.d[7:0]     = 8'(seq);
      f.v          = VW'(vc);
      return f;
   endfunction

   // Packet of n flits from one PE; the first nexp of them are expected out, in order.
   task automatic push_pkt(input int pe, input int n, input int vc, input int nexp);
      flit_t     f;
      logic [1:0] ty;
      for (int s = 0; s < n; s++) begin
         if (n == 1)          ty = 2'b11;
         else if (s == 0)     ty = 2'b01;
         else if (s == n - 1) ty = 2'b10;
         else                 ty = 2'b00;
         f = mk(pe, s, ty, vc);
         peq[pe].push_back(f);
         if (s < nexp) exp_q.push_back(f);
      end
   endtask

   // Output monitor: an unexpected flit compares against an all-ones sentinel.
   always @(negedge clk) begin
      if (ovalid === 1'b1) begin
         if (exp_q.size() > 0) mon_e = exp_q.pop_front();
         else                  mon_e = '1;
         check("odata", odata, 64'(mon_e.d));
         check("ovch", 64'(ovch), 64'(mon_e.v));
      end
   end

   // One clock: drive at negedge, sample ack before posedge, retire acked flits after it.
   task automatic cycle();
      logic [VCH:0] ret;
      ret = cred_pulse;
      if (auto_ret && ovalid === 1'b1) ret[ovch] = 1'b1;
      credit_in = ret;
      for (int i = 0; i < NPE; i++) begin
         if (peq[i].size() > 0) begin
            pe_valid[i]           = 1'b1;
            pe_data[i*FW +: FW]   = peq[i][0].d;
            pe_vch[i*VW +: VW]    = peq[i][0].v;
         end else begin
            pe_valid[i]           = 1'b0;
         end
      end
      #2;
      last_ack = pe_ack;
      check("ack_onehot", 64'($onehot0(last_ack)), 64'd1);
      check("ack_subset", 64'(last_ack & ~pe_valid), 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NPE; i++) begin
         if (last_ack[i]) begin
            void'(peq[i].pop_front());
            ack_cnt[i]++;
         end
      end
      cred_pulse = '0;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      rst_ = 1'b1;
      for (int i = 0; i < NPE; i++) begin
         peq[i].delete();
         ack_cnt[i] = 0;
      end
      cycle();
      rst_ = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_       = 1'b1;
      pe_valid   = '0;
      pe_data    = '0;
      pe_vch     = '0;
      credit_in  = '0;
      cred_pulse = '0;
      auto_ret   = 1'b0;
      last_ack   = '0;
      @(negedge clk);
      do_reset();

      check("rst_ovalid", 64'(ovalid), 64'd0);
      check("rst_odata", odata, 64'd0);
      check("rst_ovch", 64'(ovch), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_grant", 64'(grant_id), 64'd0);
      check("rst_ack", 64'(pe_ack), 64'd0);

      // Single head+tail flit on VC1, then prove VC1 has 3 credits left.
      push_pkt(2, 1, 1, 1);
      cycle();
      check("t1_ack", 64'(last_ack), 64'b0100);
      check("t1_ovalid", 64'(ovalid), 64'd1);
      check("t1_ovch", 64'(ovch), 64'd1);
      for (int s = 1; s <= 4; s++) begin
         peq[2].push_back(mk(2, s, 2'b11, 1));
         exp_q.push_back(mk(2, s, 2'b11, 1));
      end
      run(8);
      check("t1_vc1_credits", 64'(ack_cnt[2]), 64'd4);
      cred_pulse[1] = 1'b1;
      run(4);
      check("t1_vc1_release", 64'(ack_cnt[2]), 64'd5);
      check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

      // Two 3-flit packets contending on VC0: no interleave, no bubble.
      do_reset();
      auto_ret = 1'b1;
      push_pkt(0, 3, 0, 3);
      push_pkt(1, 3, 0, 3);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         check("t2_ovalid", 64'(ovalid), 64'd1);
         if (k == 1) begin
            check("t2_first_ack", 64'(last_ack), 64'b0001);
            check("t2_busy", 64'(busy), 64'd1);
            check("t2_grant0", 64'(grant_id), 64'd0);
         end
         if (k == 4) check("t2_grant1", 64'(grant_id), 64'd1);
      end
      check("t2_idle", 64'(busy), 64'd0);
      cycle();
      check("t2_gap", 64'(ovalid), 64'd0);
      check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
      auto_ret = 1'b0;

      // Credit exhaustion on a 6-flit packet.
      do_reset();
      push_pkt(3, 6, 0, 6);
      run(8);
      check("t3_stall_cnt", 64'(ack_cnt[3]), 64'd4);
      check("t3_stall_ack", 64'(last_ack), 64'd0);
      check("t3_stall_busy", 64'(busy), 64'd1);
      for (int p = 0; p < 2; p++) begin
         cred_pulse[0] = 1'b1;
         run(3);
         check("t3_release", 64'(ack_cnt[3]), 64'(5 + p));
      end
      run(1);
      check("t3_done", 64'(busy), 64'd0);
      check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

      // Send and credit return together at credit 2 leave it at 2.
      do_reset();
      push_pkt(0, 1, 0, 1);
      push_pkt(0, 1, 0, 1);
      push_pkt(0, 1, 0, 1);
      push_pkt(0, 1, 0, 1);
      push_pkt(0, 1, 0, 1);
      push_pkt(0, 1, 0, 0);
      run(2);
      cred_pulse[0] = 1'b1;
      run(7);
      check("t4_both_cnt", 64'(ack_cnt[0]), 64'd5);
      check("t4_no_err", 64'(err), 64'd0);
      check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

      // Returns at full saturate and flag an error.
      do_reset();
      cred_pulse[0] = 1'b1;
      cycle();
      check("t4_ovf_err", 64'(err), 64'd1);
      for (int p = 0; p < 4; p++) begin
         cred_pulse[0] = 1'b1;
         cycle();
      end
      for (int s = 0; s < 5; s++) push_pkt(0, 1, 0, (s < 4) ? 1 : 0);
      run(8);
      check("t4_sat_cnt", 64'(ack_cnt[0]), 64'd4);
      check("t4_err_sticky", 64'(err), 64'd1);
      check("t4_sb_empty2", 64'(exp_q.size()), 64'd0);
      do_reset();
      check("t4_err_cleared", 64'(err), 64'd0);

      // Fairness: all PEs streaming single-flit packets.
      auto_ret = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < NPE; p++) begin
            peq[p].push_back(mk(p, r, 2'b11, p % 2));
            exp_q.push_back(mk(p, r, 2'b11, p % 2));
         end
      end
      for (int k = 0; k < 12; k++) begin
         cycle();
         check("t5_order", 64'(last_ack), 64'(1 << (k % NPE)));
      end
      run(2);
      for (int p = 0; p < NPE; p++) check("t5_share", 64'(ack_cnt[p]), 64'd3);
      check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
      auto_ret = 1'b0;

      // Reset after a head abandons the packet and restores credits.
      do_reset();
      push_pkt(0, 3, 0, 1);
      cycle();
      check("t6_head_ack", 64'(last_ack), 64'b0001);
      do_reset();
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_ovalid", 64'(ovalid), 64'd0);
      push_pkt(1, 5, 0, 4);
      cycle();
      check("t6_new_head", 64'(last_ack), 64'b0010);
      run(7);
      check("t6_credits", 64'(ack_cnt[1]), 64'd4);
      check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

      // Non-head flit presented while idle.
      do_reset();
      peq[1].push_back(mk(1, 0, 2'b00, 0));
      cycle();
      check("t7_no_ack", 64'(last_ack), 64'd0);
      check("t7_err", 64'(err), 64'd1);
      check("t7_ovalid", 64'(ovalid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
